// File: rtl/sha256_pkg.sv
// Shared constants and types for the SHA-256 mining path.
// Holds feeder defaults plus the round constants used by the core.
package sha256_pkg;

  localparam int PIPE_LAT_DEF  = 24;
  localparam int NONCE_W_DEF   = 32;
  localparam int NONCE_LSB_DEF = 416;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } feeder_state_t;

  localparam logic [0:7][31:0] H0 = {
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  localparam logic [0:63][31:0] K = {
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

endpackage

// File: rtl/sha256_nonce_feeder_tag_pipe.sv
// Validity tags travelling alongside blocks inside the core.
// empty_o means no tag remains behind the output stage.
module tag_pipe #(
  parameter int DEPTH = 24
) (
  input  logic clk,
  input  logic reset,
  input  logic clr_i,
  input  logic in_i,
  output logic out_o,
  output logic empty_o
);

  logic [DEPTH-1:0] tag_q, tag_d;

  always_comb begin
    tag_d = {tag_q[DEPTH-2:0], in_i};
    if (clr_i) tag_d = '0;
  end

  always_ff @(posedge clk) begin
    if (!reset) tag_q <= '0;
    else        tag_q <= tag_d;
  end

  assign out_o   = tag_q[DEPTH-1];
  assign empty_o = ~|tag_q[DEPTH-2:0];

endmodule

// File: rtl/sha256_nonce_feeder.sv
// Streams nonce candidates into the SHA-256 pipeline core and
// reports the first tagged match or exhaustion of the range.
module sha256_nonce_feeder
  import sha256_pkg::*;
#(
  parameter int PIPE_LAT  = PIPE_LAT_DEF,
  parameter int NONCE_LSB = NONCE_LSB_DEF,
  parameter int NONCE_W   = NONCE_W_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start_i,
  input  logic [511:0]       template_i,
  input  logic [7:0]         difficulty_i,
  input  logic [NONCE_W-1:0] nonce_start_i,
  input  logic [NONCE_W-1:0] nonce_count_i,
  output logic               busy_o,
  output logic               done_o,
  output logic               found_o,
  output logic [NONCE_W-1:0] nonce_o,
  output logic [255:0]       hash_o,
  output logic [511:0]       blk_o,
  output logic [7:0]         num_zero_o,
  input  logic [255:0]       core_hash_i,
  input  logic [511:0]       core_original_i,
  input  logic               core_matched_i
);

  localparam int NHI = NONCE_LSB + NONCE_W - 1;

  feeder_state_t state_q, state_d;

  logic [511:0]       tmpl_q, tmpl_d;
  logic [511:0]       blk_q, blk_d;
  logic [7:0]         diff_q, diff_d;
  logic [NONCE_W-1:0] nonce_q, nonce_d;
  logic [NONCE_W-1:0] cnt_q, cnt_d;
  logic [NONCE_W-1:0] res_q, res_d;
  logic [255:0]       hash_q, hash_d;
  logic               found_q, found_d;

  logic tag_out, tag_empty;
  logic tag_push, tag_clr;
  logic active, match, last;
  logic unused_orig;

  function automatic logic [511:0] splice(
    input logic [511:0]       t,
    input logic [NONCE_W-1:0] n
  );
    logic [511:0] r;
    r = t;
    r[NHI:NONCE_LSB] = n;
    return r;
  endfunction

  assign active = (state_q == RUN) || (state_q == DRAIN);
  assign match  = active && core_matched_i && tag_out;
  assign last   = (cnt_q == NONCE_W'(1));

  assign unused_orig = ^{core_original_i[511:NHI+1],
                         core_original_i[NONCE_LSB-1:0]};

  tag_pipe #(
    .DEPTH(PIPE_LAT)
  ) u_tag (
    .clk    (clk),
    .reset  (reset),
    .clr_i  (tag_clr),
    .in_i   (tag_push),
    .out_o  (tag_out),
    .empty_o(tag_empty)
  );

  always_ff @(posedge clk) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (start_i)
          state_d = (nonce_count_i == '0) ? DONE : RUN;
      end
      RUN: begin
        if (match)     state_d = DONE;
        else if (last) state_d = DRAIN;
      end
      DRAIN: begin
        if (match || tag_empty) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy_o   = (state_q != IDLE);
    done_o   = (state_q == DONE);
    tag_push = (state_q == RUN);
    tag_clr  = match;
  end

  always_comb begin
    tmpl_d  = tmpl_q;
    blk_d   = blk_q;
    diff_d  = diff_q;
    nonce_d = nonce_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    hash_d  = hash_q;
    found_d = found_q;
    if (state_q == IDLE && start_i) begin
      tmpl_d  = template_i;
      diff_d  = difficulty_i;
      nonce_d = nonce_start_i;
      cnt_d   = nonce_count_i;
      res_d   = '0;
      hash_d  = '0;
      found_d = 1'b0;
      if (nonce_count_i != '0)
        blk_d = splice(template_i, nonce_start_i);
    end
    if (state_q == RUN && !match && !last) begin
      nonce_d = nonce_q + 1'b1;
      cnt_d   = cnt_q - 1'b1;
      blk_d   = splice(tmpl_q, nonce_q + 1'b1);
    end
    if (match) begin
      found_d = 1'b1;
      res_d   = core_original_i[NHI:NONCE_LSB];
      hash_d  = core_hash_i;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      tmpl_q  <= '0;
      blk_q   <= '0;
      diff_q  <= '0;
      nonce_q <= '0;
      cnt_q   <= '0;
      res_q   <= '0;
      hash_q  <= '0;
      found_q <= 1'b0;
    end else begin
      tmpl_q  <= tmpl_d;
      blk_q   <= blk_d;
      diff_q  <= diff_d;
      nonce_q <= nonce_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
      hash_q  <= hash_d;
      found_q <= found_d;
    end
  end

  assign blk_o      = blk_q;
  assign num_zero_o = diff_q;
  assign found_o    = found_q;
  assign nonce_o    = res_q;
  assign hash_o     = hash_q;

endmodule

// File: tb/tb_sha256_nonce_feeder.sv
// Bench for sha256_nonce_feeder with a 24-cycle core stub
// and a scoreboard of expected job completions.
module tb_sha256_nonce_feeder;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         start_i = 1'b0;
  logic [511:0] template_i = '0;
  logic [7:0]   difficulty_i = '0;
  logic [31:0]  nonce_start_i = '0;
  logic [31:0]  nonce_count_i = '0;
  logic         busy_o, done_o, found_o;
  logic [31:0]  nonce_o;
  logic [255:0] hash_o;
  logic [511:0] blk_o;
  logic [7:0]   num_zero_o;
  logic [255:0] core_hash_i;
  logic [511:0] core_original_i;
  logic         core_matched_i;

  logic         stray = 1'b0;
  logic         match_en = 1'b0;
  logic [31:0]  match_nonce = '0;
  logic [511:0] stub_q [24];
  logic [31:0]  orig_n;
  int unsigned  cyc = 0;
  int           passed = 0;
  int           total = 0;

  typedef struct {
    int unsigned  cyc;
    logic         found;
    logic [31:0]  nonce;
    logic [255:0] hash;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    for (int i = 23; i > 0; i--) stub_q[i] <= stub_q[i-1];
    stub_q[0] <= blk_o;
  end

  function automatic logic [255:0] hash_fn(input logic [31:0] n);
    return {8{n ^ 32'hC3A5_0F1E}};
  endfunction

  function automatic logic [511:0] splice(
    input logic [511:0] t,
    input logic [31:0]  n
  );
    logic [511:0] r;
    r = t;
    r[447:416] = n;
    return r;
  endfunction

  function automatic logic [511:0] rand_blk();
    logic [511:0] r;
    for (int i = 0; i < 16; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  assign core_original_i = stub_q[23];
  assign orig_n          = core_original_i[447:416];
  assign core_hash_i     = hash_fn(orig_n);
  assign core_matched_i  = stray || (match_en && orig_n == match_nonce);

  sha256_nonce_feeder dut (
    .clk            (clk),
    .reset          (reset),
    .start_i        (start_i),
    .template_i     (template_i),
    .difficulty_i   (difficulty_i),
    .nonce_start_i  (nonce_start_i),
    .nonce_count_i  (nonce_count_i),
    .busy_o         (busy_o),
    .done_o         (done_o),
    .found_o        (found_o),
    .nonce_o        (nonce_o),
    .hash_o         (hash_o),
    .blk_o          (blk_o),
    .num_zero_o     (num_zero_o),
    .core_hash_i    (core_hash_i),
    .core_original_i(core_original_i),
    .core_matched_i (core_matched_i)
  );

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic launch(
    input  logic [31:0] ns,
    input  logic [31:0] nc,
    input  logic [7:0]  d,
    output int unsigned c
  );
    start_i       = 1'b1;
    nonce_start_i = ns;
    nonce_count_i = nc;
    difficulty_i  = d;
    c = cyc;
    tick();
    start_i = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      if (done_o) seen = 1'b1;
      else tick();
    end
  endtask

  task automatic test_reset();
    int hits;
    reset = 1'b0;
    repeat (3) tick();
    reset = 1'b1;
    tick();
    total++;
    if ({busy_o, done_o, found_o} !== 3'b000)
      $display("FAIL reset_flags: got %b want 000",
               {busy_o, done_o, found_o});
    else passed++;
    total++;
    if (nonce_o !== '0 || hash_o !== '0)
      $display("FAIL reset_result: got %h %h want 0", nonce_o, hash_o);
    else passed++;
    total++;
    if (blk_o !== '0 || num_zero_o !== '0)
      $display("FAIL reset_core: got nz %h want 0", num_zero_o);
    else passed++;
    hits = 0;
    stray = 1'b1;
    tick();
    stray = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (done_o || busy_o) hits++;
      tick();
    end
    total++;
    if (hits != 0)
      $display("FAIL idle_stray: got %0d pulses want 0", hits);
    else passed++;
  endtask

  task automatic test_no_match();
    logic [511:0] t;
    int unsigned c;
    bit seen;
    exp_t e;
    t = rand_blk();
    template_i = t;
    match_en = 1'b0;
    launch(32'h10, 32'd4, 8'd8, c);
    sb.push_back('{c + 29, 1'b0, 32'h0, 256'h0});
    for (int i = 0; i < 4; i++) begin
      total++;
      if (blk_o !== splice(t, 32'h10 + i) || !busy_o)
        $display("FAIL nm_blk%0d: got %h want %h", i,
                 blk_o[447:416], 32'h10 + i);
      else passed++;
      tick();
    end
    total++;
    if (num_zero_o !== 8'd8)
      $display("FAIL nm_numzero: got %0d want 8", num_zero_o);
    else passed++;
    wait_done(80, seen);
    e = sb.pop_front();
    total++;
    if (!seen || cyc != e.cyc)
      $display("FAIL nm_done: got cyc %0d seen %0b want %0d",
               cyc, seen, e.cyc);
    else passed++;
    total++;
    if (found_o !== e.found || nonce_o !== e.nonce)
      $display("FAIL nm_found: got %b %h want %b %h",
               found_o, nonce_o, e.found, e.nonce);
    else passed++;
    tick();
    total++;
    if (busy_o !== 1'b0 || done_o !== 1'b0)
      $display("FAIL nm_busy_fall: got %b%b want 00", busy_o, done_o);
    else passed++;
  endtask

  task automatic test_match();
    int unsigned c;
    bit seen;
    int hits;
    exp_t e;
    template_i = rand_blk();
    match_nonce = 32'h12;
    match_en = 1'b1;
    launch(32'h10, 32'd4, 8'd20, c);
    sb.push_back('{c + 28, 1'b1, 32'h12, hash_fn(32'h12)});
    wait_done(80, seen);
    e = sb.pop_front();
    total++;
    if (!seen || cyc != e.cyc)
      $display("FAIL mt_done: got cyc %0d seen %0b want %0d",
               cyc, seen, e.cyc);
    else passed++;
    total++;
    if (found_o !== e.found || nonce_o !== e.nonce)
      $display("FAIL mt_nonce: got %b %h want %b %h",
               found_o, nonce_o, e.found, e.nonce);
    else passed++;
    total++;
    if (hash_o !== e.hash)
      $display("FAIL mt_hash: got %h want %h", hash_o, e.hash);
    else passed++;
    match_en = 1'b0;
    tick();
    total++;
    if (busy_o !== 1'b0)
      $display("FAIL mt_busy_fall: got %b want 0", busy_o);
    else passed++;
    hits = 0;
    stray = 1'b1;
    repeat (3) tick();
    stray = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (done_o) hits++;
      tick();
    end
    total++;
    if (hits != 0 || nonce_o !== e.nonce || found_o !== 1'b1)
      $display("FAIL mt_stray: got %0d pulses nonce %h want 0 %h",
               hits, nonce_o, e.nonce);
    else passed++;
  endtask

  task automatic test_wrap();
    logic [511:0] t;
    logic [31:0] n;
    int unsigned c;
    bit seen;
    exp_t e;
    t = rand_blk();
    template_i = t;
    match_nonce = 32'h0;
    match_en = 1'b1;
    launch(32'hFFFF_FFFE, 32'd4, 8'd16, c);
    sb.push_back('{c + 28, 1'b1, 32'h0, hash_fn(32'h0)});
    n = 32'hFFFF_FFFE;
    for (int i = 0; i < 4; i++) begin
      total++;
      if (blk_o !== splice(t, n))
        $display("FAIL wr_blk%0d: got %h want %h", i,
                 blk_o[447:416], n);
      else passed++;
      n = n + 1;
      tick();
    end
    wait_done(80, seen);
    e = sb.pop_front();
    total++;
    if (!seen || cyc != e.cyc || found_o !== e.found)
      $display("FAIL wr_done: got cyc %0d found %b want %0d %b",
               cyc, found_o, e.cyc, e.found);
    else passed++;
    total++;
    if (nonce_o !== e.nonce || hash_o !== e.hash)
      $display("FAIL wr_result: got %h want %h", nonce_o, e.nonce);
    else passed++;
    match_en = 1'b0;
    repeat (2) tick();
  endtask

  task automatic test_back_to_back();
    logic [511:0] t;
    int unsigned c;
    bit seen;
    exp_t e;
    template_i = rand_blk();
    launch(32'h40, 32'd0, 8'd5, c);
    sb.push_back('{c + 1, 1'b0, 32'h0, 256'h0});
    wait_done(10, seen);
    e = sb.pop_front();
    total++;
    if (!seen || cyc != e.cyc || found_o !== e.found)
      $display("FAIL em_done: got cyc %0d found %b want %0d 0",
               cyc, found_o, e.cyc);
    else passed++;
    tick();
    total++;
    if (busy_o !== 1'b0)
      $display("FAIL em_busy_fall: got %b want 0", busy_o);
    else passed++;
    t = rand_blk();
    template_i = t;
    launch(32'h100, 32'd3, 8'd9, c);
    sb.push_back('{c + 28, 1'b0, 32'h0, 256'h0});
    total++;
    if (blk_o !== splice(t, 32'h100))
      $display("FAIL bb_blk0: got %h want 100", blk_o[447:416]);
    else passed++;
    start_i = 1'b1;
    nonce_start_i = 32'h500;
    nonce_count_i = 32'd0;
    difficulty_i = 8'h77;
    template_i = rand_blk();
    tick();
    start_i = 1'b0;
    for (int i = 1; i < 3; i++) begin
      total++;
      if (blk_o !== splice(t, 32'h100 + i))
        $display("FAIL bb_blk%0d: got %h want %h", i,
                 blk_o[447:416], 32'h100 + i);
      else passed++;
      tick();
    end
    total++;
    if (num_zero_o !== 8'd9)
      $display("FAIL bb_numzero: got %0d want 9", num_zero_o);
    else passed++;
    wait_done(80, seen);
    e = sb.pop_front();
    total++;
    if (!seen || cyc != e.cyc || found_o !== e.found)
      $display("FAIL bb_done: got cyc %0d found %b want %0d 0",
               cyc, found_o, e.cyc);
    else passed++;
    repeat (2) tick();
  endtask

  task automatic test_reset_mid();
    int unsigned c;
    int hits;
    template_i = rand_blk();
    match_nonce = 32'h203;
    match_en = 1'b1;
    launch(32'h200, 32'd8, 8'd4, c);
    while (cyc < c + 10) tick();
    reset = 1'b0;
    tick();
    reset = 1'b1;
    total++;
    if (busy_o !== 1'b0 || found_o !== 1'b0)
      $display("FAIL rm_abort: got busy %b found %b want 0 0",
               busy_o, found_o);
    else passed++;
    hits = 0;
    for (int i = 0; i < 40; i++) begin
      if (done_o || busy_o) hits++;
      tick();
    end
    total++;
    if (hits != 0 || found_o !== 1'b0)
      $display("FAIL rm_ignore: got %0d pulses found %b want 0 0",
               hits, found_o);
    else passed++;
    match_en = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1, "timeout");
  end

  initial begin
    tick();
    test_reset();
    test_no_match();
    test_match();
    test_wrap();
    test_back_to_back();
    test_reset_mid();
    total++;
    if (sb.size() != 0)
      $display("FAIL sb_leftover: got %0d want 0", sb.size());
    else passed++;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
